// File: rtl/regfile_port_arb_pkg.sv
// Shared CPU sizing constants, read-FSM state encoding and round-robin
// pointer values for the register-file port arbiter.
package regfile_port_arb_pkg;

    localparam int CPU_CAP       = 4;
    localparam int CPU_REG_COUNT = 3;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_RESP  = 2'd2
    } rd_state_e;

    // Identity of the requester granted most recently.
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

endpackage

// File: rtl/regfile_port_arb_rr_arb2.sv
// Two-way round-robin arbiter: grants are combinational, and the last-grant
// pointer advances only when a grant (and therefore a transfer) happens.
module rr_arb2
    import regfile_port_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic       last_q;
    logic       last_d;
    logic [1:0] gnt_raw;

    always_comb begin
        gnt_raw = 2'b00;
        unique case (req_i)
            2'b01:   gnt_raw = 2'b01;
            2'b10:   gnt_raw = 2'b10;
            2'b11:   gnt_raw = (last_q == RR_B) ? 2'b01 : 2'b10;
            default: gnt_raw = 2'b00;
        endcase
    end

    // Nothing is granted while reset is held, even with requests present.
    assign gnt_o = rst_ni ? gnt_raw : 2'b00;

    always_comb begin
        last_d = last_q;
        if (gnt_o[0]) begin
            last_d = RR_A;
        end else if (gnt_o[1]) begin
            last_d = RR_B;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= RR_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_port_arb.sv
// Register-file port arbiter: two write requesters share the single write
// port via round robin; a three-state FSM sequences reads with RAW hazard hold.
//
// state    | meaning
// RD_IDLE  | waiting for a hazard-free read request
// RD_ISSUE | rf_r_en high, latched addresses on rf_raddr
// RD_RESP  | rd_valid high, rd_data carries the sampled read data
module regfile_port_arb
    import regfile_port_arb_pkg::*;
#(
    parameter int CAP       = CPU_CAP,
    parameter int REG_COUNT = CPU_REG_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wa_valid,
    input  logic [CAP-1:0]   wa_addr,
    input  logic [CAP-1:0]   wa_data,
    output logic             wa_ready,
    input  logic             wb_valid,
    input  logic [CAP-1:0]   wb_addr,
    input  logic [CAP-1:0]   wb_data,
    output logic             wb_ready,
    input  logic             rd_req,
    input  logic [2*CAP-1:0] rd_addr,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [2*CAP-1:0] rd_data,
    output logic             rf_w_en,
    output logic [CAP-1:0]   rf_waddr,
    output logic [CAP-1:0]   rf_wdata,
    output logic             rf_r_en,
    output logic [2*CAP-1:0] rf_raddr,
    input  logic [2*CAP-1:0] rf_rdata
);

    localparam logic [CAP-1:0] REG_LIMIT = CAP'(REG_COUNT);

    logic [1:0]       gnt;
    logic             w_accept;
    logic [CAP-1:0]   w_addr;
    logic [CAP-1:0]   w_data;
    logic             rf_w_en_q;
    logic [CAP-1:0]   rf_waddr_q;
    logic [CAP-1:0]   rf_wdata_q;
    logic [CAP-1:0]   raddr0;
    logic [CAP-1:0]   raddr1;
    logic             hazard;
    logic             rd_xfer;
    rd_state_e        state_q;
    rd_state_e        state_d;
    logic [2*CAP-1:0] rf_raddr_q;
    logic [2*CAP-1:0] rd_data_q;

    rr_arb2 u_arb (
        .clk_i  (clk),
        .rst_ni (rst),
        .req_i  ({wb_valid, wa_valid}),
        .gnt_o  (gnt)
    );

    assign wa_ready = gnt[0];
    assign wb_ready = gnt[1];
    assign w_accept = |gnt;
    assign w_addr   = gnt[1] ? wb_addr : wa_addr;
    assign w_data   = gnt[1] ? wb_data : wa_data;

    // Out-of-range writes are still handshaken but never reach the regfile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_w_en_q  <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_w_en_q <= w_accept && (w_addr < REG_LIMIT);
            if (w_accept && (w_addr < REG_LIMIT)) begin
                rf_waddr_q <= w_addr;
                rf_wdata_q <= w_data;
            end
        end
    end

    assign rf_w_en  = rf_w_en_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    assign raddr0 = rd_addr[CAP-1:0];
    assign raddr1 = rd_addr[2*CAP-1:CAP];

    // A read waits until neither the write being accepted nor the one on the port targets it.
    assign hazard = (w_accept  && ((raddr0 == w_addr)     || (raddr1 == w_addr))) ||
                    (rf_w_en_q && ((raddr0 == rf_waddr_q) || (raddr1 == rf_waddr_q)));

    assign rd_ready = rst && (state_q == RD_IDLE) && !hazard;
    assign rd_xfer  = rd_req && rd_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE:  if (rd_xfer) state_d = RD_ISSUE;
            RD_ISSUE: state_d = RD_RESP;
            RD_RESP:  state_d = RD_IDLE;
            default:  state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RD_IDLE;
            rf_raddr_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (rd_xfer) begin
                rf_raddr_q <= rd_addr;
            end
            if (state_q == RD_ISSUE) begin
                rd_data_q <= rf_rdata;
            end
        end
    end

    assign rf_r_en  = (state_q == RD_ISSUE);
    assign rf_raddr = rf_raddr_q;
    assign rd_valid = (state_q == RD_RESP);
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_regfile_port_arb.sv
// Directed bench for regfile_port_arb with a small regfile behind it; expected
// writes and read responses are queued by stimulus and checked by a monitor.
module tb_regfile_port_arb;

    localparam int CAP       = 4;
    localparam int REG_COUNT = 3;

    logic             clk;
    logic             rst;
    logic             wa_valid, wb_valid;
    logic [CAP-1:0]   wa_addr, wa_data, wb_addr, wb_data;
    logic             wa_ready, wb_ready;
    logic             rd_req, rd_ready, rd_valid;
    logic [2*CAP-1:0] rd_addr, rd_data;
    logic             rf_w_en, rf_r_en;
    logic [CAP-1:0]   rf_waddr, rf_wdata;
    logic [2*CAP-1:0] rf_raddr, rf_rdata;

    logic [CAP-1:0]   regs [REG_COUNT];
    logic [2*CAP-1:0] wq [$];
    logic [2*CAP-1:0] rq [$];

    int checks   = 0;
    int failures = 0;
    int seen_rv;

    regfile_port_arb #(.CAP(CAP), .REG_COUNT(REG_COUNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .wa_valid (wa_valid),
        .wa_addr  (wa_addr),
        .wa_data  (wa_data),
        .wa_ready (wa_ready),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_ready (wb_ready),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rf_w_en  (rf_w_en),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_r_en  (rf_r_en),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [CAP-1:0] rf_rd(input logic [CAP-1:0] a);
        if (a < CAP'(REG_COUNT)) return regs[a];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (rf_w_en && (rf_waddr < CAP'(REG_COUNT))) regs[rf_waddr] <= rf_wdata;
    end

    assign rf_rdata = {rf_rd(rf_raddr[2*CAP-1:CAP]), rf_rd(rf_raddr[CAP-1:0])};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, "_wa_ready"}, 32'(wa_ready), 0);
        check({tag, "_wb_ready"}, 32'(wb_ready), 0);
        check({tag, "_rd_ready"}, 32'(rd_ready), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rf_w_en"},  32'(rf_w_en), 0);
        check({tag, "_rf_r_en"},  32'(rf_r_en), 0);
        check({tag, "_rd_data"},  32'(rd_data), 0);
        check({tag, "_rf_waddr"}, 32'(rf_waddr), 0);
        check({tag, "_rf_wdata"}, 32'(rf_wdata), 0);
        check({tag, "_rf_raddr"}, 32'(rf_raddr), 0);
    endtask

    // Scoreboard monitor: every presented write/read response must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (rf_w_en) begin
                if (wq.size() == 0) check("wr_unexpected", 32'({rf_waddr, rf_wdata}), 32'hFFFF_FFFF);
                else check("wr_port", 32'({rf_waddr, rf_wdata}), 32'(wq.pop_front()));
            end
            if (rd_valid) begin
                if (rq.size() == 0) check("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
                else check("rd_resp", 32'(rd_data), 32'(rq.pop_front()));
            end
        end
    end

    initial begin
        for (int i = 0; i < REG_COUNT; i++) regs[i] = '0;
        rst = 1'b0;
        wa_valid = 1'b1; wa_addr = 4'd1; wa_data = 4'd5;
        wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 4'd9;
        rd_req = 1'b0; rd_addr = '0;

        // Reset with both writers already requesting, then A first, B next.
        cyc(); cyc();
        mid();
        chk_all_zero("por");
        cyc();
        rst = 1'b1;
        mid();
        check("t1_c0_wa_ready", 32'(wa_ready), 1);
        check("t1_c0_wb_ready", 32'(wb_ready), 0);
        wq.push_back({4'd1, 4'd5});
        cyc();
        wa_valid = 1'b0;
        mid();
        check("t1_c1_wb_ready", 32'(wb_ready), 1);
        wq.push_back({4'd2, 4'd9});
        cyc();
        wb_valid = 1'b0;
        cyc(); cyc();
        check("t1_ebx", 32'(regs[1]), 5);
        check("t1_ecx", 32'(regs[2]), 9);

        // Four cycles of contention: A,B,A,B and rf_w_en four cycles in a row.
        wa_valid = 1'b1; wa_addr = 4'd0;
        wb_valid = 1'b1; wb_addr = 4'd1;
        for (int i = 0; i < 4; i++) begin
            wa_data = 4'(1 + i);
            wb_data = 4'(8 + i);
            mid();
            check("t2_wa_ready", 32'(wa_ready), (i % 2 == 0) ? 1 : 0);
            check("t2_wb_ready", 32'(wb_ready), (i % 2 == 1) ? 1 : 0);
            if (i > 0) check("t2_rf_w_en", 32'(rf_w_en), 1);
            if (i % 2 == 0) wq.push_back({4'd0, 4'(1 + i)});
            else            wq.push_back({4'd1, 4'(8 + i)});
            cyc();
        end
        wa_valid = 1'b0; wb_valid = 1'b0;
        mid();
        check("t2_rf_w_en_last", 32'(rf_w_en), 1);
        cyc();
        mid();
        check("t2_rf_w_en_off", 32'(rf_w_en), 0);
        cyc();

        // Read-after-write hazard on register 1.
        wa_valid = 1'b1; wa_addr = 4'd1; wa_data = 4'd7;
        rd_req = 1'b1; rd_addr = {4'd0, 4'd1};
        mid();
        check("t3_c0_wa_ready", 32'(wa_ready), 1);
        check("t3_c0_rd_ready", 32'(rd_ready), 0);
        wq.push_back({4'd1, 4'd7});
        cyc();
        wa_valid = 1'b0;
        mid();
        check("t3_c1_rd_ready", 32'(rd_ready), 0);
        cyc();
        mid();
        check("t3_c2_rd_ready", 32'(rd_ready), 1);
        rq.push_back({4'd3, 4'd7});
        cyc();
        rd_req = 1'b0;
        mid();
        check("t3_issue_r_en", 32'(rf_r_en), 1);
        check("t3_issue_raddr", 32'(rf_raddr), 32'h01);
        check("t3_issue_rd_valid", 32'(rd_valid), 0);
        cyc();
        mid();
        check("t3_c4_rd_valid", 32'(rd_valid), 1);
        cyc();
        mid();
        check("t3_c5_rd_valid", 32'(rd_valid), 0);
        check("t3_rd_data_hold", 32'(rd_data), 32'h37);
        check("t3_r_en_off", 32'(rf_r_en), 0);
        cyc();

        // Out-of-range write is handshaken and dropped.
        wa_valid = 1'b1; wa_addr = 4'd3; wa_data = 4'hF;
        mid();
        check("t4_wa_ready", 32'(wa_ready), 1);
        cyc();
        wa_valid = 1'b0;
        mid();
        check("t4_rf_w_en", 32'(rf_w_en), 0);
        cyc();
        check("t4_eax", 32'(regs[0]), 3);
        check("t4_ebx", 32'(regs[1]), 7);
        check("t4_ecx", 32'(regs[2]), 9);

        // Reset while the read is in ISSUE; the read must vanish.
        rd_req = 1'b1; rd_addr = {4'd2, 4'd1};
        mid();
        check("t5_rd_ready", 32'(rd_ready), 1);
        cyc();
        rd_req = 1'b0;
        mid();
        check("t5_issue_r_en", 32'(rf_r_en), 1);
        rst = 1'b0;
        wa_valid = 1'b1; wa_addr = 4'd0; wa_data = 4'hC;
        wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 4'd6;
        #1;
        chk_all_zero("midrst");
        seen_rv = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            mid();
            if (rd_valid) seen_rv++;
        end
        cyc();
        rst = 1'b1;
        mid();
        check("t5_rel_rf_w_en", 32'(rf_w_en), 0);
        check("t5_rel_wa_ready", 32'(wa_ready), 1);
        check("t5_rel_wb_ready", 32'(wb_ready), 0);
        if (rd_valid) seen_rv++;
        wq.push_back({4'd0, 4'hC});
        cyc();
        wa_valid = 1'b0; wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            if (rd_valid) seen_rv++;
            cyc();
        end
        check("t5_no_rd_valid", 32'(seen_rv), 0);

        rd_req = 1'b1; rd_addr = {4'd2, 4'd1};
        mid();
        check("t5_next_rd_ready", 32'(rd_ready), 1);
        rq.push_back({4'd9, 4'd7});
        cyc();
        rd_req = 1'b0;
        mid();
        check("t5_next_issue", 32'(rf_r_en), 1);
        cyc();
        mid();
        check("t5_next_rd_valid", 32'(rd_valid), 1);
        cyc(); cyc(); cyc();

        check("wq_drained", 32'(wq.size()), 0);
        check("rq_drained", 32'(rq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_port_arb.md
REGFILE_PORT_ARB -- requirements
Module: regfile_port_arb

Interface
REQ-001 The block SHALL have parameter CAP, default `CAP (4), data/address width.
REQ-002 The block SHALL have parameter REG_COUNT, default `REG_COUNT (3), number of architectural registers.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port wa_valid  input  1  write requester A (ALU writeback) request.
REQ-006 The block SHALL have port wa_addr  input  CAP  requester A target register.
REQ-007 The block SHALL have port wa_data  input  CAP  requester A write data.
REQ-008 The block SHALL have port wa_ready  output  1  requester A grant; transfer when wa_valid&wa_ready.
REQ-009 The block SHALL have ports wb_valid/wb_addr/wb_data (input 1/CAP/CAP) and wb_ready (output 1), requester B (load path), same semantics as A.
REQ-010 The block SHALL have port rd_req  input  1  read request.
REQ-011 The block SHALL have port rd_addr  input  2*CAP  {raddr1, raddr0}.
REQ-012 The block SHALL have port rd_ready  output  1  read accepted when rd_req&rd_ready.
REQ-013 The block SHALL have ports rd_valid (output 1) and rd_data (output 2*CAP, {rdata1, rdata0}), read response.
REQ-014 The block SHALL have ports rf_w_en (output 1), rf_waddr (output CAP), rf_wdata (output CAP), driving the regfile write port.
REQ-015 The block SHALL have ports rf_r_en (output 1), rf_raddr (output 2*CAP), rf_rdata (input 2*CAP), driving the regfile read ports.

Function
REQ-016 Write arbitration SHALL be two-way round robin; grant is combinational, at most one of wa_ready/wb_ready high per cycle.
REQ-017 A lone valid requester SHALL be granted the same cycle; on a tie the requester not granted last SHALL win; pointer updates only on a transfer.
REQ-018 An accepted write SHALL appear registered on rf_w_en=1, rf_waddr, rf_wdata for exactly the next cycle (latency 1); no transfer -> rf_w_en=0.
REQ-019 A write with addr >= REG_COUNT SHALL be accepted and discarded (rf_w_en stays 0).
REQ-020 Read FSM SHALL have states IDLE, ISSUE, RESP: IDLE->ISSUE on read transfer; ISSUE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-021 rd_ready SHALL be 1 only in IDLE with no hazard; in ISSUE/RESP rd_req is ignored.
REQ-022 Hazard SHALL be: either read address equals the waddr of a write being accepted this cycle or currently on rf_w_en=1; hazard holds rd_ready=0 until clear.
REQ-023 In ISSUE rf_r_en=1 and rf_raddr = latched rd_addr; elsewhere rf_r_en=0, rf_raddr holds.
REQ-024 In RESP rd_valid=1 for exactly one cycle with rd_data = rf_rdata sampled at end of ISSUE; rd_data holds until next RESP.
REQ-025 Read and write paths SHALL operate independently in the same cycle when no hazard.

Reset
REQ-026 While rst=0: wa_ready, wb_ready, rd_ready, rd_valid, rf_w_en, rf_r_en = 0; rd_data, rf_waddr, rf_wdata, rf_raddr = 0; read FSM = IDLE; RR pointer = B (A wins first tie).
REQ-027 Reset mid-operation SHALL drop any in-flight write or read; no rd_valid for an aborted read.

Structure
REQ-028 CAP and REG_COUNT SHALL come from the shared cpu.vh header; FSM state encodings SHALL be local parameters.
REQ-029 Arbitration SHALL be a sub-module rr_arb2 (2 requests, grants, registered last-grant pointer).

Verification (bench instantiates regfile behind the block)
REQ-030 Assert rst=0 mid-run -> all outputs 0 immediately; after release, rf_w_en=0 and A wins first tie.
REQ-031 wa (addr 1, data 5) and wb (addr 2, data 9) both valid from reset -> wa_ready cycle 0, wb_ready cycle 1; regfile ebx=5, ecx=9.
REQ-032 Both valid for 4 consecutive cycles -> grant sequence A,B,A,B; rf_w_en high 4 consecutive cycles.
REQ-033 Write addr 1 data 7 accepted cycle 0, rd_req addr {0,1} cycle 0 -> rd_ready=0 cycles 0-1, accepted cycle 2, rd_valid cycle 4 with rdata0=7.
REQ-034 wa_addr=3 data F -> wa_ready=1, rf_w_en stays 0, eax/ebx/ecx unchanged.
REQ-035 rst=0 while FSM in ISSUE -> rd_valid never asserts; FSM IDLE after release, next read completes normally.
